// File: rtl/glitch_scheduler.sv
// Trigger-to-glitch timing controller: turns a qualified trigger edge into a
// programmed train of enable / enable_specific pulses for the glitch injector.
module glitch_scheduler #(
  parameter int DELAY_W = 16,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic               cfg_specific,
  output logic               enable,
  output logic               enable_specific,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   glitch_count
);

  // One shared down-counter serves delay, pulse length and gap phases.
  localparam int MW = (LEN_W > CNT_W) ? LEN_W : CNT_W;
  localparam int CW = (DELAY_W > MW) ? DELAY_W : MW;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP} state_e;

  state_e             state_q;
  logic               trig_q;
  logic [CW-1:0]      cnt_q;
  logic [DELAY_W-1:0] delay_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   gap_q;
  logic               spec_q;
  logic               en_q;
  logic               ens_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   gcnt_q;

  logic trig_edge;
  logic pulse_on;
  logic last_pulse;
  logic cnt_one;

  assign trig_edge  = trigger & ~trig_q;
  assign pulse_on   = en_q | ens_q;
  assign last_pulse = (gcnt_q >= num_q);
  assign cnt_one    = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      delay_q <= '0;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      spec_q  <= 1'b0;
      en_q    <= 1'b0;
      ens_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      trig_q <= trigger;
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        ens_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm && !abort) begin
              // Zero-valued fields are clamped once here so later phases never see 0.
              delay_q <= cfg_delay;
              len_q   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
              num_q   <= (cfg_num == '0) ? CNT_W'(1) : cfg_num;
              gap_q   <= (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
              spec_q  <= cfg_specific;
              gcnt_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trig_edge) begin
              if (delay_q == '0) begin
                state_q <= S_GLITCH;
              end else begin
                cnt_q   <= CW'(delay_q);
                state_q <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (cnt_one) state_q <= S_GLITCH;
            else         cnt_q   <= cnt_q - CW'(1);
          end
          S_GLITCH: begin
            if (!pulse_on) begin
              en_q   <= ~spec_q;
              ens_q  <= spec_q;
              cnt_q  <= CW'(len_q);
              gcnt_q <= (gcnt_q == '1) ? gcnt_q : gcnt_q + CNT_W'(1);
            end else if (cnt_one) begin
              en_q  <= 1'b0;
              ens_q <= 1'b0;
              if (last_pulse) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                cnt_q   <= CW'(gap_q);
                state_q <= S_GAP;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_GAP: begin
            // The next pulse rises on the edge that ends the gap.
            if (cnt_one) begin
              en_q    <= ~spec_q;
              ens_q   <= spec_q;
              cnt_q   <= CW'(len_q);
              gcnt_q  <= (gcnt_q == '1) ? gcnt_q : gcnt_q + CNT_W'(1);
              state_q <= S_GLITCH;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign enable          = en_q;
  assign enable_specific = ens_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign glitch_count    = gcnt_q;

endmodule

// File: tb/tb_glitch_scheduler.sv
// Randomized self-checking bench for glitch_scheduler against a pulse-train arithmetic model.
module tb_glitch_scheduler;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm, abort, trigger, cfg_specific;
  logic [DW-1:0] cfg_delay;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_num, cfg_gap;
  logic          enable, enable_specific, busy, done;
  logic [CW-1:0] glitch_count;

  int n_cmp = 0;
  int n_bad = 0;

  glitch_scheduler #(.DELAY_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset_n), .arm(arm), .abort(abort), .trigger(trigger),
    .cfg_delay(cfg_delay), .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_gap(cfg_gap),
    .cfg_specific(cfg_specific), .enable(enable), .enable_specific(enable_specific),
    .busy(busy), .done(done), .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: pulse p starts k = 1 + d + p*(L+G) cycles after the trigger edge and lasts L.
  function automatic logic m_pulse(int k, int d, int l, int n, int g);
    for (int p = 0; p < n; p++) begin
      int s;
      s = 1 + d + p * (l + g);
      if (k >= s && k < s + l) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_count(int k, int d, int l, int n, int g);
    int c;
    c = 0;
    for (int p = 0; p < n; p++)
      if (k >= 1 + d + p * (l + g)) c++;
    return c;
  endfunction

  task automatic randomize_cfg;
    cfg_delay    = DW'($urandom);
    cfg_len      = LW'($urandom);
    cfg_num      = CW'($urandom);
    cfg_gap      = CW'($urandom);
    cfg_specific = 1'($urandom);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arm = 1'($urandom); trigger = 1'($urandom);
      step;
      n_cmp++;
      if ({enable, enable_specific, busy, done, glitch_count} !== 12'h0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %b required 0", i,
                 {enable, enable_specific, busy, done, glitch_count});
      end
    end
    arm = 1'b0; trigger = 1'b0;
    reset_n = 1'b1;
    step;
    n_cmp++;
    if ({enable, enable_specific, busy, done, glitch_count} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_release: got %b required 0",
               {enable, enable_specific, busy, done, glitch_count});
    end
  endtask

  // Directed rows (single pulse, specific burst, zero clamping, max delay) then random ones.
  // During each run, arm/cfg/trigger noise checks that busy ignores arm and cfg changes.
  task automatic test_sequences;
    int d_t[4] = '{5, 0, 0, 65535};
    int l_t[4] = '{3, 2, 0, 1};
    int n_t[4] = '{1, 3, 0, 1};
    int g_t[4] = '{0, 4, 0, 0};
    bit s_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int r = 0; r < 14; r++) begin
      int d, l, n, g, dk, cnt;
      bit sp, p;
      logic [11:0] e;
      if (r < 4) begin
        d = d_t[r]; l = l_t[r]; n = n_t[r]; g = g_t[r]; sp = s_t[r];
      end else begin
        d = $urandom_range(0, 12); l = $urandom_range(0, 4);
        n = $urandom_range(0, 4);  g = $urandom_range(0, 4);
        sp = 1'($urandom);
      end
      trigger = 1'b0; abort = 1'b0;
      cfg_delay = DW'(d); cfg_len = LW'(l); cfg_num = CW'(n); cfg_gap = CW'(g);
      cfg_specific = sp;
      arm = 1'b1;
      step;
      arm = 1'b0;
      randomize_cfg;
      if (l == 0) l = 1;
      if (n == 0) n = 1;
      if (g == 0) g = 1;
      dk = 1 + d + n * l + (n - 1) * g;
      step; step;
      n_cmp++;
      if ({enable, enable_specific, busy, done, glitch_count} !== 12'b0010_0000_0000) begin
        n_bad++;
        $display("FAIL armed_wait[row %0d]: got %b required 001000000000", r,
                 {enable, enable_specific, busy, done, glitch_count});
      end
      trigger = 1'b1;
      step;
      for (int k = 0; k <= dk + 3; k++) begin
        if (k > 0) step;
        p   = m_pulse(k, d, l, n, g);
        cnt = m_count(k, d, l, n, g);
        e   = {(sp ? 1'b0 : p), (sp ? p : 1'b0), (k < dk), (k == dk), CW'(cnt)};
        n_cmp++;
        if ({enable, enable_specific, busy, done, glitch_count} !== e) begin
          n_bad++;
          $display("FAIL seq[row %0d k %0d d %0d l %0d n %0d g %0d sp %0d]: got %b required %b",
                   r, k, d, l, n, g, sp,
                   {enable, enable_specific, busy, done, glitch_count}, e);
        end
        trigger = 1'($urandom);
        arm = (k + 1 <= dk) ? 1'($urandom) : 1'b0;
        randomize_cfg;
      end
      arm = 1'b0; trigger = 1'b0;
      step;
    end
  endtask

  task automatic test_abort;
    trigger = 1'b0; abort = 1'b0;
    cfg_delay = 16'd2; cfg_len = 8'd3; cfg_num = 8'd4; cfg_gap = 8'd2; cfg_specific = 1'b0;
    arm = 1'b1; step; arm = 1'b0;
    step;
    trigger = 1'b1; step;
    for (int k = 1; k <= 9; k++) step;
    n_cmp++;
    if ({enable, glitch_count} !== {1'b1, 8'd2}) begin
      n_bad++;
      $display("FAIL abort_pre: got en=%b cnt=%0d required en=1 cnt=2", enable, glitch_count);
    end
    abort = 1'b1;
    step;
    abort = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if ({enable, enable_specific, busy, done, glitch_count} !== {4'b0000, 8'd2}) begin
        n_bad++;
        $display("FAIL abort_post[%0d]: got %b required 000000000010", k,
                 {enable, enable_specific, busy, done, glitch_count});
      end
      step;
    end
  endtask

  task automatic test_reset_mid_pulse;
    trigger = 1'b0;
    cfg_delay = 16'd0; cfg_len = 8'd8; cfg_num = 8'd1; cfg_gap = 8'd1; cfg_specific = 1'b0;
    arm = 1'b1; step; arm = 1'b0;
    trigger = 1'b1; step;
    step; step;
    n_cmp++;
    if (enable !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got en=%b required 1", enable);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({enable, enable_specific, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %b required 000", {enable, enable_specific, busy});
    end
    trigger = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step;
  endtask

  task automatic test_edge_qual;
    cfg_delay = 16'd1; cfg_len = 8'd1; cfg_num = 8'd1; cfg_gap = 8'd1; cfg_specific = 1'b1;
    trigger = 1'b1;
    step;
    arm = 1'b1; step; arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      n_cmp++;
      if ({enable, enable_specific, busy, done} !== 4'b0010) begin
        n_bad++;
        $display("FAIL edge_qual_hold[%0d]: got %b required 0010", i,
                 {enable, enable_specific, busy, done});
      end
    end
    trigger = 1'b0; step;
    trigger = 1'b1; step;
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] e;
      step;
      e = {1'b0, m_pulse(k, 1, 1, 1, 1), (k < 3), (k == 3)};
      n_cmp++;
      if ({enable, enable_specific, busy, done} !== e) begin
        n_bad++;
        $display("FAIL edge_qual_run[k %0d]: got %b required %b", k,
                 {enable, enable_specific, busy, done}, e);
      end
    end
    trigger = 1'b0;
    step;
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    cfg_delay = '0; cfg_len = '0; cfg_num = '0; cfg_gap = '0; cfg_specific = 1'b0;
    test_reset;
    test_sequences;
    test_abort;
    test_reset_mid_pulse;
    test_edge_qual;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/glitch_scheduler.md
Name: glitch_scheduler

Overview:
- Timing controller directly upstream of the glitch injector.
- Converts a trigger event from the core under test into precisely timed `enable` / `enable_specific` pulses that drive the injector.
- Programmable trigger-to-glitch delay, pulse width, pulse count and inter-pulse gap.
- Used by fault-injection testbenches to hit a chosen instruction cycle of the dual-core pair.

Parameters:
- DELAY_W, 16, width of trigger-to-first-glitch delay field (cycles)
- LEN_W, 8, width of glitch pulse length field (cycles)
- CNT_W, 8, width of pulse-count and gap fields

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle request; latches configuration, enters ARMED
- abort  in  1  synchronous cancel of any activity
- trigger  in  1  level from the DUT; a 0->1 transition starts the sequence
- cfg_delay  in  DELAY_W  cycles between trigger edge and first pulse
- cfg_len  in  LEN_W  pulse length in cycles (0 treated as 1)
- cfg_num  in  CNT_W  number of pulses (0 treated as 1)
- cfg_gap  in  CNT_W  low cycles between pulses (0 treated as 1)
- cfg_specific  in  1  1 = pulses drive enable_specific, 0 = pulses drive enable
- enable  out  1  to injector: random glitch request
- enable_specific  out  1  to injector: force-specific-value request
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the final pulse completes
- glitch_count  out  CNT_W  pulses issued since the last arm

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, trigger-history register 0.
- Reset mid-pulse: the asynchronous reset drops enable/enable_specific immediately, without waiting for a clock edge.
- All outputs are registered. enable and enable_specific are never high simultaneously.
- States: IDLE, ARMED, DELAY, GLITCH, GAP.
- IDLE:
  - arm=1 latches cfg_*, clears glitch_count, goes to ARMED.
  - cfg_* changes after the latch have no effect on the sequence in progress.
- ARMED:
  - Edge detect: trig_q holds the previous-cycle trigger; an edge is trigger=1 while trig_q=0.
  - A trigger already high when ARMED is entered does not count; a new 0->1 transition is required.
  - Let the edge be sampled at clock edge T.
  - If delay=0: go to GLITCH; the selected enable output is high from edge T+1.
  - Otherwise: go to DELAY with the counter loaded to delay.
- DELAY: counter decrements each cycle; the pulse output is high from edge T+1+delay.
- GLITCH:
  - Selected output is high for exactly max(cfg_len,1) cycles.
  - glitch_count increments on the cycle the pulse output rises. It saturates at its max value; it does not wrap.
  - At pulse end: if pulses issued < max(cfg_num,1), go to GAP. Otherwise the output falls, done=1 for one cycle, go to IDLE.
- GAP: output low for max(cfg_gap,1) cycles, then back to GLITCH.
- abort=1, any non-IDLE state: next edge goes to IDLE. enable/enable_specific=0, done stays 0, glitch_count holds its value.
- abort has priority over arm and trigger in the same cycle.
- arm while busy is ignored, including arm coinciding with done; a new arm needs IDLE.
- trigger edges outside ARMED are ignored.
- Counters are sized to their cfg fields; a maximum delay of 2^DELAY_W-1 is legal and must not overflow.

Test Plan:
- Reset sequencing: reset=0 for 3 cycles while arm/trigger toggle -> all outputs 0. Release -> state IDLE, busy=0.
- Single pulse: arm with delay=5, len=3, num=1, cfg_specific=0; trigger edge at edge T -> enable high at edges T+6..T+8; done=1 at T+9; glitch_count=1; enable_specific never high.
- Burst, specific mode: delay=0, len=2, num=3, gap=4, cfg_specific=1 -> enable_specific high T+1..T+2, T+7..T+8, T+13..T+14; done at T+15; glitch_count=3; enable stays 0.
- Zero-field clamping: len=0, num=0, gap=0, delay=0 -> a single 1-cycle pulse at T+1, then done.
- Abort and reset mid-burst: abort asserted during the 2nd pulse of num=4 -> output low next edge, busy=0, done never asserted, glitch_count=2. Separately, reset asserted mid-pulse -> enable falls without a clock edge.
- Edge qualification: trigger already high before arm -> no pulse until trigger goes 0 then 1. Arm issued while busy -> config unchanged, timing matches the original settings.
